// File: rtl/fetch_thread_sched_pkg.sv
// Shared types for the fetch thread scheduler: thread id, per-thread state and default width.
package fetch_thread_sched_pkg;

  localparam int NTHREADS_DEFAULT = 4;

  typedef logic [1:0] threadid_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READY     = 2'd1,
    MISS_WAIT = 2'd2,
    BACKOFF   = 2'd3
  } thread_state_e;

endpackage

// File: rtl/fetch_thread_sched_if.sv
// Event inputs, fetch handshake and status bundle of the fetch thread scheduler.
interface fetch_thread_sched_if
  import fetch_thread_sched_pkg::*;
#(
  parameter int NTHREADS = NTHREADS_DEFAULT
);

  logic [NTHREADS-1:0] thread_enable;
  logic                miss_valid;
  threadid_t           miss_thread;
  logic                fill_done;
  threadid_t           fill_thread;
  logic                hazard_valid;
  threadid_t           hazard_thread;
  logic                fetch_ready;
  logic                fetch_valid;
  threadid_t           fetch_thread;
  logic [NTHREADS-1:0] stalled_mask;

  // master is the scheduler, slave is the front end around it
  modport master (
    input  thread_enable, miss_valid, miss_thread, fill_done, fill_thread,
           hazard_valid, hazard_thread, fetch_ready,
    output fetch_valid, fetch_thread, stalled_mask
  );

  modport slave (
    output thread_enable, miss_valid, miss_thread, fill_done, fill_thread,
           hazard_valid, hazard_thread, fetch_ready,
    input  fetch_valid, fetch_thread, stalled_mask
  );

endinterface

// File: rtl/fetch_thread_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after last+1, wrapping.
module rr_arbiter
  import fetch_thread_sched_pkg::*;
#(
  parameter int NTHREADS = NTHREADS_DEFAULT
) (
  input  logic [NTHREADS-1:0] req,
  input  threadid_t           last,
  output logic [NTHREADS-1:0] grant,
  output threadid_t           grant_idx
);

  always_comb begin
    threadid_t cand;
    logic      found;
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    // k == NTHREADS wraps back onto last itself, so it is considered last
    for (int k = 1; k <= NTHREADS; k++) begin
      cand = last + threadid_t'(k);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fetch_thread_sched.sv
// Per-thread fetch FSMs (idle/ready/miss-wait/backoff) feeding a registered round-robin grant.
module fetch_thread_sched
  import fetch_thread_sched_pkg::*;
#(
  parameter int NTHREADS    = NTHREADS_DEFAULT,
  parameter int HAZ_BACKOFF = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_thread_sched_if.master bus
);

  localparam int CNT_W = $clog2(HAZ_BACKOFF + 1);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_READY   = READY;
  localparam logic [1:0] ST_MISS    = MISS_WAIT;
  localparam logic [1:0] ST_BACKOFF = BACKOFF;

  typedef logic [CNT_W-1:0] cnt_t;

  logic [NTHREADS-1:0] elig;
  logic [NTHREADS-1:0] stall_nxt;
  logic [NTHREADS-1:0] arb_grant;
  logic [NTHREADS-1:0] stall_q;
  threadid_t           arb_idx;
  threadid_t           arb_last;
  threadid_t           last_q;
  threadid_t           thread_q;
  logic                arb_any;
  logic                valid_q;
  logic                xfer;
  logic                hold;

  for (genvar i = 0; i < NTHREADS; i++) begin : g_thr
    logic       miss_i;
    logic       haz_i;
    logic       fill_i;
    logic [1:0] state_q;
    logic [1:0] state_d;
    cnt_t       cnt_q;
    cnt_t       cnt_d;

    assign miss_i = bus.miss_valid   && (bus.miss_thread   == threadid_t'(i));
    assign haz_i  = bus.hazard_valid && (bus.hazard_thread == threadid_t'(i));
    assign fill_i = bus.fill_done    && (bus.fill_thread   == threadid_t'(i));

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!bus.thread_enable[i]) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          ST_IDLE: state_d = ST_READY;
          ST_READY, ST_BACKOFF: begin
            // miss outranks hazard; a hazard in backoff reloads the count
            if (miss_i) begin
              state_d = ST_MISS;
              cnt_d   = '0;
            end else if (haz_i) begin
              state_d = ST_BACKOFF;
              cnt_d   = cnt_t'(HAZ_BACKOFF);
            end else if (state_q == ST_BACKOFF) begin
              if (cnt_q == cnt_t'(1)) begin
                state_d = ST_READY;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q - cnt_t'(1);
              end
            end
          end
          ST_MISS: if (fill_i && !miss_i) state_d = ST_READY;
          default: state_d = ST_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign elig[i]      = (state_q == ST_READY) && bus.thread_enable[i] && !miss_i && !haz_i;
    assign stall_nxt[i] = (state_d == ST_MISS) || (state_d == ST_BACKOFF);
  end

  rr_arbiter #(.NTHREADS(NTHREADS)) u_arb (
    .req       (elig),
    .last      (arb_last),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign arb_any  = |arb_grant;
  assign xfer     = valid_q && bus.fetch_ready;
  // a stalled offer is kept only while its thread remains eligible
  assign hold     = valid_q && !bus.fetch_ready && elig[thread_q];
  assign arb_last = xfer ? thread_q : last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      thread_q <= '0;
      last_q   <= threadid_t'(NTHREADS - 1);
      stall_q  <= '0;
    end else begin
      last_q  <= arb_last;
      stall_q <= stall_nxt;
      if (!hold) begin
        valid_q <= arb_any;
        if (arb_any) thread_q <= arb_idx;
      end
    end
  end

  assign bus.fetch_valid  = valid_q;
  assign bus.fetch_thread = thread_q;
  assign bus.stalled_mask = stall_q;

endmodule

// File: tb/tb_fetch_thread_sched.sv
// Scenario and random-stimulus bench for fetch_thread_sched against a per-thread reference model.
module tb_fetch_thread_sched;
  import fetch_thread_sched_pkg::*;

  localparam int NT = 4;
  localparam int HB = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_thread_sched_if #(.NTHREADS(NT)) bus ();

  fetch_thread_sched #(.NTHREADS(NT), .HAZ_BACKOFF(HB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // model: running = thread enabled and out of idle; waiting = miss pending; bo_left = backoff edges left
  bit running [NT];
  bit waiting [NT];
  int bo_left [NT];
  bit exp_valid;
  int exp_thread;
  int last_m;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_stall();
    logic [31:0] m = '0;
    for (int i = 0; i < NT; i++)
      if (running[i] && (waiting[i] || bo_left[i] > 0)) m[i] = 1'b1;
    return m;
  endfunction

  task automatic model_edge();
    bit elig [NT];
    bit mi, hi, fi, en;
    int w;
    if (rst) begin
      for (int i = 0; i < NT; i++) begin
        running[i] = 0; waiting[i] = 0; bo_left[i] = 0;
      end
      exp_valid = 0; exp_thread = 0; last_m = NT - 1;
      return;
    end
    for (int i = 0; i < NT; i++) begin
      mi = bus.miss_valid && (int'(bus.miss_thread) == i);
      hi = bus.hazard_valid && (int'(bus.hazard_thread) == i);
      elig[i] = running[i] && !waiting[i] && (bo_left[i] == 0) &&
                bus.thread_enable[i] && !mi && !hi;
    end
    if (exp_valid && bus.fetch_ready) last_m = exp_thread;
    if (!(exp_valid && !bus.fetch_ready && elig[exp_thread])) begin
      w = -1;
      for (int k = 1; k <= NT; k++)
        if (w < 0 && elig[(last_m + k) % NT]) w = (last_m + k) % NT;
      exp_valid = (w >= 0);
      if (w >= 0) exp_thread = w;
    end
    for (int i = 0; i < NT; i++) begin
      mi = bus.miss_valid && (int'(bus.miss_thread) == i);
      hi = bus.hazard_valid && (int'(bus.hazard_thread) == i);
      fi = bus.fill_done && (int'(bus.fill_thread) == i);
      en = bus.thread_enable[i];
      if (!en) begin
        running[i] = 0; waiting[i] = 0; bo_left[i] = 0;
      end else if (!running[i]) begin
        running[i] = 1;
      end else if (waiting[i]) begin
        if (fi && !mi) waiting[i] = 0;
      end else if (mi) begin
        waiting[i] = 1; bo_left[i] = 0;
      end else if (hi) begin
        bo_left[i] = HB;
      end else if (bo_left[i] > 0) begin
        bo_left[i]--;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("fetch_valid", bus.fetch_valid, exp_valid);
    chk("fetch_thread", bus.fetch_thread, exp_thread);
    chk("stalled_mask", bus.stalled_mask, exp_stall());
  endtask

  task automatic clear_ev();
    bus.miss_valid = 0; bus.miss_thread = '0;
    bus.fill_done = 0; bus.fill_thread = '0;
    bus.hazard_valid = 0; bus.hazard_thread = '0;
  endtask

  task automatic miss(int t);
    bus.miss_valid = 1; bus.miss_thread = threadid_t'(t);
  endtask

  task automatic fill(int t);
    bus.fill_done = 1; bus.fill_thread = threadid_t'(t);
  endtask

  task automatic hazard(int t);
    bus.hazard_valid = 1; bus.hazard_thread = threadid_t'(t);
  endtask

  initial begin
    rst = 1; bus.thread_enable = '0; bus.fetch_ready = 0; clear_ev();
    step(); step();

    // round-robin sequence from reset
    rst = 0; bus.thread_enable = 4'b1111; bus.fetch_ready = 1;
    step();
    chk("seq_first_idle", bus.fetch_valid, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("seq_valid", bus.fetch_valid, 1);
      chk("seq_thread", bus.fetch_thread, k % NT);
    end

    // miss then fill on thread 1
    miss(1); step(); clear_ev();
    chk("miss_stall1", bus.stalled_mask[1], 1);
    repeat (4) step();
    fill(1); step(); clear_ev();
    chk("fill_unstall1", bus.stalled_mask[1], 0);
    repeat (4) step();

    // hazard on thread 2, reloaded during backoff
    hazard(2); step(); clear_ev();
    step();
    hazard(2); step(); clear_ev();
    repeat (6) step();

    // held offer, withdrawn by a miss on the held thread
    rst = 1; step();
    rst = 0; bus.fetch_ready = 0; step(); step();
    chk("hold_valid", bus.fetch_valid, 1);
    chk("hold_thread", bus.fetch_thread, 0);
    step();
    miss(0); step(); clear_ev();
    chk("withdraw_thread", bus.fetch_thread, 1);
    step(); step();
    bus.fetch_ready = 1;
    fill(0); step(); clear_ev();

    // same-edge miss and fill for a waiting thread
    miss(3); step(); clear_ev();
    step();
    miss(3); fill(3); step(); clear_ev();
    chk("miss_fill_stall3", bus.stalled_mask[3], 1);
    fill(3); step(); clear_ev();
    step();

    // disable during miss wait, stray fill, re-enable, then reset mid-run
    miss(1); step(); clear_ev();
    bus.thread_enable = 4'b1101; step();
    fill(1); step(); clear_ev();
    chk("disabled_stall1", bus.stalled_mask[1], 0);
    bus.thread_enable = 4'b1111; step(); step(); step();
    miss(2); hazard(0); rst = 1; step(); clear_ev();
    chk("rst_valid", bus.fetch_valid, 0);
    chk("rst_stall", bus.stalled_mask, 0);
    rst = 0;

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(199) == 0);
      for (int i = 0; i < NT; i++)
        if ($urandom_range(99) < 3) bus.thread_enable[i] = ~bus.thread_enable[i];
      bus.miss_valid    = ($urandom_range(99) < 12);
      bus.miss_thread   = threadid_t'($urandom_range(NT - 1));
      bus.fill_done     = ($urandom_range(99) < 30);
      bus.fill_thread   = threadid_t'($urandom_range(NT - 1));
      bus.hazard_valid  = ($urandom_range(99) < 15);
      bus.hazard_thread = threadid_t'($urandom_range(NT - 1));
      bus.fetch_ready   = ($urandom_range(99) < 70);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
